seg7_scan_decoder: RTL and testbench
====================================

# seg7_scan_decoder

Receiver for the multiplexed 4-digit seven-segment bus that the display top levels drive (active-low anodes `an3..an0`, active-low segments `a..g`, `dp`). It samples the scanned lines and rebuilds the four displayed characters as codes. It publishes a complete frame once every digit has been captured. It sits on the board-level loopback and self-check path next to the display drivers, so message-scrolling designs can be checked automatically rather than by eye.

## Interface
- `SETTLE_CYCLES`, default 4: consecutive identical cycles a selected digit must hold before it is captured (range 1..255).
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `an3`, `an2`, `an1`, `an0` in 1 each: digit selects, active-low; `an0` is the rightmost digit.
- `a`, `b`, `c`, `d`, `e`, `f`, `g`, `dp` in 1 each: segment lines, active-low.
- `char3`..`char0` out 5 each: decoded character per digit. Codes 0x00–0x0F are hex glyphs, 0x10 is blank, 0x1F is unknown.
- `dp3`..`dp0` out 1 each: decimal point per digit, active-high.
- `frame_valid` out 1: one-cycle pulse when a new frame is published.
- `frame_changed` out 1: one-cycle pulse, coincident with `frame_valid`, when any `char`/`dp` differs from the previous frame.
- `glyph_err` out 1: one-cycle pulse when a captured pattern maps to 0x1F.
- `select_err` out 1: one-cycle pulse on each cycle where more than one anode is low.

## Operation
- Inputs are registered once before use. The registered copy is `sel = ~{an3..an0}` and `seg = ~{g,f,e,d,c,b,a}`.
- Valid select means exactly one bit of `sel` is set. No anode low means idle. Two or more anodes low is a select error; it forces the stable counter to 0 and performs no capture.
- Stable counter, 8-bit:
  - Increments while the select is valid and `{sel,seg,dp}` equals the previous cycle's value.
  - Resets to 0 on any difference.
  - Saturates at `SETTLE_CYCLES`.
- Capture happens when the counter reaches `SETTLE_CYCLES` and the per-period `captured` flag is clear. The capture:
  - writes the decoded char and dp into slot `idx(sel)`;
  - sets bit `idx` in a 4-bit mask;
  - sets `captured`.
  
  `captured` clears whenever `sel` changes. A digit is therefore captured at most once per anode-active period.
- A slot re-captured before the frame completes is overwritten with the newest value.
- Frame publish happens when the mask reaches 4'b1111. On publish:
  - slots are copied to the outputs;
  - `frame_valid` pulses;
  - `frame_changed` is computed against the previously published outputs;
  - the mask clears.
- Decode table (`seg` as gfedcba, active-high) → code:
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7
  - 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F
  - 00→0x10 (blank)
  - anything else → 0x1F, with a `glyph_err` pulse in the capture cycle.
- FSM states:
  - IDLE: no valid select.
  - SETTLE: counting.
  - HELD: captured, waiting for `sel` change.
  
  Transitions:
  - IDLE→SETTLE on a valid select.
  - SETTLE→HELD on capture.
  - Any→IDLE on no-select or select error.
  - HELD/SETTLE→SETTLE on `sel` or `seg` change.

## Timing
- Reset values: `char*` = 0x10, `dp*` = 0, all pulses 0, mask 0, counter 0, state IDLE. The first frame's `frame_changed` is compared against this blank frame.
- Capture latency is 1 input-register cycle plus `SETTLE_CYCLES` cycles after the lines become stable.
- Publish timing:
  - `char*`/`dp*` update and `frame_valid` assert in the cycle after the fourth capture.
  - Outputs are registered and hold until the next publish.
- Capture and publish in the same edge: the slot written is included in the published frame.
- Anode switch during settle: the counter restarts and no partial capture occurs.
- `reset` mid-frame: the mask and slots clear immediately; published outputs return to their reset values.
- Scan period is unconstrained. Only the settle requirement applies.

## Test plan
- Reset, then scan "1234" with each anode held 20 cycles, `SETTLE_CYCLES`=4 → first `frame_valid` after the fourth digit: `char3..0` = 1,2,3,4, `frame_changed` = 1. The second identical frame gives `frame_valid` = 1 and `frame_changed` = 0.
- Digit held only 3 cycles, then switched → no capture and no `frame_valid` until that digit is held ≥4 stable cycles.
- Drive `an1` and `an0` low together for 5 cycles → `select_err` high for 5 cycles; mask unchanged.
- Segment pattern 0x49 on digit 2 → `glyph_err` pulse; the published `char2` = 0x1F.
- Segments glitch mid-hold (bounce-like toggle every 2 cycles for 10 cycles), then stable "A" → single capture, `char` = 0x0A.
- Assert `reset` after 2 captures, release, then scan "00F0" → `frame_valid` only after 4 fresh captures; `char` = 0,0,F,0; `dp` all 0.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// Loopback receiver for a multiplexed 4-digit seven-segment bus: debounces each
// scanned digit, decodes it to a character code and publishes complete frames.
module seg7_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       an3,
  input  logic       an2,
  input  logic       an1,
  input  logic       an0,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  input  logic       dp,
  output logic [4:0] char3,
  output logic [4:0] char2,
  output logic [4:0] char1,
  output logic [4:0] char0,
  output logic       dp3,
  output logic       dp2,
  output logic       dp1,
  output logic       dp0,
  output logic       frame_valid,
  output logic       frame_changed,
  output logic       glyph_err,
  output logic       select_err
);

  localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);
  localparam logic [4:0] CODE_BLANK = 5'h10;
  localparam logic [4:0] CODE_UNKNOWN = 5'h1F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } state_t;

  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h3F:   decode = 5'h00;
      7'h06:   decode = 5'h01;
      7'h5B:   decode = 5'h02;
      7'h4F:   decode = 5'h03;
      7'h66:   decode = 5'h04;
      7'h6D:   decode = 5'h05;
      7'h7D:   decode = 5'h06;
      7'h07:   decode = 5'h07;
      7'h7F:   decode = 5'h08;
      7'h6F:   decode = 5'h09;
      7'h77:   decode = 5'h0A;
      7'h7C:   decode = 5'h0B;
      7'h39:   decode = 5'h0C;
      7'h5E:   decode = 5'h0D;
      7'h79:   decode = 5'h0E;
      7'h71:   decode = 5'h0F;
      7'h00:   decode = CODE_BLANK;
      default: decode = CODE_UNKNOWN;
    endcase
  endfunction

  function automatic logic [1:0] sel_idx(input logic [3:0] s);
    case (s)
      4'b0010: sel_idx = 2'd1;
      4'b0100: sel_idx = 2'd2;
      4'b1000: sel_idx = 2'd3;
      default: sel_idx = 2'd0;
    endcase
  endfunction

  logic [3:0]       r_sel;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic [11:0]      r_prev;
  logic [7:0]       r_cnt;
  logic             r_captured;
  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_mask;
  logic [3:0][4:0]  r_slot_char;
  logic [3:0]       r_slot_dp;
  logic [3:0][4:0]  r_out_char;
  logic [3:0]       r_out_dp;
  logic             r_frame_valid;
  logic             r_frame_changed;
  logic             r_glyph_err;
  logic             r_select_err;

  logic             w_any;
  logic             w_multi;
  logic             w_valid;
  logic             w_same;
  logic             w_sel_chg;
  logic [7:0]       w_cnt_next;
  logic             w_capture;
  logic [4:0]       w_code;
  logic [3:0][4:0]  w_slot_char;
  logic [3:0]       w_slot_dp;
  logic [3:0]       w_mask_next;
  logic             w_publish;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel  <= 4'd0;
      r_seg  <= 7'd0;
      r_dp   <= 1'b0;
      r_prev <= 12'd0;
    end else begin
      r_sel  <= ~{an3, an2, an1, an0};
      r_seg  <= ~{g, f, e, d, c, b, a};
      r_dp   <= ~dp;
      r_prev <= {r_sel, r_seg, r_dp};
    end
  end

  always_comb begin
    w_any      = (r_sel != 4'd0);
    w_multi    = ((r_sel & (r_sel - 4'd1)) != 4'd0);
    w_valid    = w_any && !w_multi;
    w_same     = ({r_sel, r_seg, r_dp} == r_prev);
    w_sel_chg  = (r_sel != r_prev[11:8]);
    w_cnt_next = 8'd0;
    if (!w_valid || !w_same) begin
      w_cnt_next = 8'd0;
    end else if (r_cnt >= SETTLE) begin
      w_cnt_next = SETTLE;
    end else begin
      w_cnt_next = r_cnt + 8'd1;
    end
    w_capture = (r_state == ST_SETTLE) && w_valid && !r_captured && (w_cnt_next == SETTLE);
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_valid) w_state_next = ST_SETTLE;
        else         w_state_next = ST_IDLE;
      end
      ST_SETTLE: begin
        if (!w_valid)      w_state_next = ST_IDLE;
        else if (w_capture) w_state_next = ST_HELD;
        else               w_state_next = ST_SETTLE;
      end
      ST_HELD: begin
        if (!w_valid)     w_state_next = ST_IDLE;
        else if (!w_same) w_state_next = ST_SETTLE;
        else              w_state_next = ST_HELD;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Slot update and frame completion; a capture on the last digit is folded into the publish.
  always_comb begin
    w_code      = decode(r_seg);
    w_slot_char = r_slot_char;
    w_slot_dp   = r_slot_dp;
    w_mask_next = r_mask;
    if (w_capture) begin
      w_slot_char[sel_idx(r_sel)] = w_code;
      w_slot_dp[sel_idx(r_sel)]   = r_dp;
      w_mask_next                 = r_mask | r_sel;
    end else begin
      w_mask_next = r_mask;
    end
    w_publish = w_capture && (w_mask_next == 4'hF);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_cnt           <= 8'd0;
      r_captured      <= 1'b0;
      r_mask          <= 4'd0;
      r_slot_char     <= {4{CODE_BLANK}};
      r_slot_dp       <= 4'd0;
      r_out_char      <= {4{CODE_BLANK}};
      r_out_dp        <= 4'd0;
      r_frame_valid   <= 1'b0;
      r_frame_changed <= 1'b0;
      r_glyph_err     <= 1'b0;
      r_select_err    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_slot_char <= w_slot_char;
      r_slot_dp   <= w_slot_dp;
      r_mask      <= w_publish ? 4'd0 : w_mask_next;
      if (w_sel_chg) r_captured <= 1'b0;
      else if (w_capture) r_captured <= 1'b1;
      else r_captured <= r_captured;
      if (w_publish) begin
        r_out_char      <= w_slot_char;
        r_out_dp        <= w_slot_dp;
        r_frame_changed <= ({w_slot_char, w_slot_dp} != {r_out_char, r_out_dp});
      end else begin
        r_frame_changed <= 1'b0;
      end
      r_frame_valid <= w_publish;
      r_glyph_err   <= w_capture && (w_code == CODE_UNKNOWN);
      r_select_err  <= w_multi;
    end
  end

  assign char3         = r_out_char[3];
  assign char2         = r_out_char[2];
  assign char1         = r_out_char[1];
  assign char0         = r_out_char[0];
  assign dp3           = r_out_dp[3];
  assign dp2           = r_out_dp[2];
  assign dp1           = r_out_dp[1];
  assign dp0           = r_out_dp[0];
  assign frame_valid   = r_frame_valid;
  assign frame_changed = r_frame_changed;
  assign glyph_err     = r_glyph_err;
  assign select_err    = r_select_err;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed plus randomized scans of the seven-segment bus, checked against a
// frame-level model that tracks which digits were held long enough to capture.
module tb_seg7_scan_decoder;
  localparam int SETTLE = 4;

  logic clk = 1'b0;
  logic reset;
  logic an3, an2, an1, an0;
  logic a, b, c, d, e, f, g, dp;
  logic [4:0] char3, char2, char1, char0;
  logic dp3, dp2, dp1, dp0;
  logic frame_valid, frame_changed, glyph_err, select_err;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .reset(reset),
    .an3(an3), .an2(an2), .an1(an1), .an0(an0),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp),
    .char3(char3), .char2(char2), .char1(char1), .char0(char0),
    .dp3(dp3), .dp2(dp2), .dp1(dp1), .dp0(dp0),
    .frame_valid(frame_valid), .frame_changed(frame_changed),
    .glyph_err(glyph_err), .select_err(select_err)
  );

  // gfedcba patterns, index = hex code; index 16 is blank
  logic [6:0] pat [0:16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h00};

  int n_cmp = 0;
  int n_bad = 0;
  int fv_cnt = 0;
  int glyph_cnt = 0;
  int selerr_cnt = 0;
  logic last_changed = 1'b0;

  logic [3:0][4:0] exp_slot, exp_pub;
  logic [3:0] exp_slot_dp, exp_pub_dp, exp_mask;
  int exp_fv = 0;
  logic exp_changed = 1'b0;

  // Pulse monitor, sampled just after each rising edge
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      if (frame_valid) begin
        fv_cnt <= fv_cnt + 1;
        last_changed <= frame_changed;
      end
      if (glyph_err) glyph_cnt <= glyph_cnt + 1;
      if (select_err) selerr_cnt <= selerr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_slot = {4{5'h10}};
    exp_pub = {4{5'h10}};
    exp_slot_dp = 4'd0;
    exp_pub_dp = 4'd0;
    exp_mask = 4'd0;
  endtask

  task automatic idle(input int n);
    {an3, an2, an1, an0} = 4'hF;
    {g, f, e, d, c, b, a} = 7'h7F;
    dp = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drive one digit for `hold` cycles; the model captures it only if held well past the settle time
  task automatic scan(input int pos, input logic [6:0] p, input logic [4:0] code,
                      input logic dpv, input int hold);
    logic [3:0] oh;
    oh = 4'b0000;
    oh[pos] = 1'b1;
    {an3, an2, an1, an0} = ~oh;
    {g, f, e, d, c, b, a} = ~p;
    dp = ~dpv;
    repeat (hold) @(negedge clk);
    if (hold >= SETTLE + 2) begin
      exp_slot[pos] = code;
      exp_slot_dp[pos] = dpv;
      exp_mask[pos] = 1'b1;
      if (exp_mask == 4'hF) begin
        exp_changed = (exp_slot != exp_pub) || (exp_slot_dp != exp_pub_dp);
        exp_pub = exp_slot;
        exp_pub_dp = exp_slot_dp;
        exp_mask = 4'd0;
        exp_fv++;
      end
    end
  endtask

  task automatic scan_hex(input int pos, input int code, input logic dpv, input int hold);
    scan(pos, pat[code], 5'(code), dpv, hold);
  endtask

  task automatic check_frame(input string tag);
    check({tag, " frames"}, fv_cnt, exp_fv);
    check({tag, " chars"}, {char3, char2, char1, char0}, exp_pub);
    check({tag, " dps"}, {dp3, dp2, dp1, dp0}, exp_pub_dp);
    check({tag, " changed"}, last_changed, exp_changed);
  endtask

  initial begin
    int base;
    reset = 1'b1;
    model_reset();
    idle(3);
    check("reset chars", {char3, char2, char1, char0}, {4{5'h10}});
    check("reset dps", {dp3, dp2, dp1, dp0}, 4'd0);
    check("reset pulses", {frame_valid, frame_changed, glyph_err, select_err}, 4'd0);
    reset = 1'b0;
    idle(2);

    // "1234" twice: first frame changes, second does not
    for (int k = 0; k < 2; k++) begin
      scan_hex(3, 1, 1'b0, 20);
      scan_hex(2, 2, 1'b0, 20);
      scan_hex(1, 3, 1'b0, 20);
      scan_hex(0, 4, 1'b0, 20);
      idle(3);
      check_frame("1234");
      check("1234 changed literal", last_changed, (k == 0) ? 32'd1 : 32'd0);
    end

    // Short hold on digit 1 must not complete the frame
    scan_hex(3, 5, 1'b0, 20);
    scan_hex(2, 6, 1'b1, 20);
    scan_hex(1, 7, 1'b0, 3);
    scan_hex(0, 8, 1'b0, 20);
    idle(3);
    check("short hold no frame", fv_cnt, exp_fv);
    scan_hex(1, 7, 1'b0, 20);
    idle(3);
    check_frame("short hold");

    // Two anodes low: select_err per cycle, partial mask survives
    scan_hex(3, 9, 1'b1, 20);
    idle(2);
    base = selerr_cnt;
    {an3, an2, an1, an0} = 4'b1100;
    {g, f, e, d, c, b, a} = ~pat[2];
    dp = 1'b1;
    repeat (5) @(negedge clk);
    idle(3);
    check("select_err cycles", selerr_cnt - base, 32'd5);
    check("select_err no frame", fv_cnt, exp_fv);
    scan_hex(2, 0, 1'b0, 15);
    scan_hex(1, 12, 1'b0, 15);
    scan_hex(0, 13, 1'b1, 15);
    idle(3);
    check_frame("after select_err");

    // Unknown glyph on digit 2
    base = glyph_cnt;
    scan_hex(3, 14, 1'b0, 15);
    scan(2, 7'h49, 5'h1F, 1'b0, 15);
    scan_hex(1, 15, 1'b0, 15);
    scan_hex(0, 11, 1'b0, 15);
    idle(3);
    check("glyph_err pulses", glyph_cnt - base, 32'd1);
    check("glyph char2", char2, 5'h1F);
    check_frame("glyph");

    // Bouncing segments on digit 3, then a stable "A"
    base = glyph_cnt;
    for (int k = 0; k < 5; k++) scan(3, (k % 2 == 0) ? pat[10] : 7'h49, 5'h1F, 1'b0, 2);
    scan_hex(3, 10, 1'b0, 20);
    scan_hex(2, 1, 1'b0, 15);
    scan_hex(1, 1, 1'b0, 15);
    scan_hex(0, 1, 1'b0, 15);
    idle(3);
    check("bounce glyph_err", glyph_cnt - base, 32'd0);
    check("bounce char3", char3, 5'h0A);
    check_frame("bounce");

    // Reset after two captures, then "00F0" needing four fresh captures
    scan_hex(3, 6, 1'b1, 15);
    scan_hex(2, 6, 1'b1, 15);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("midreset chars", {char3, char2, char1, char0}, {4{5'h10}});
    check("midreset dps", {dp3, dp2, dp1, dp0}, 4'd0);
    reset = 1'b0;
    idle(2);
    scan_hex(1, 15, 1'b0, 15);
    scan_hex(0, 0, 1'b0, 15);
    idle(3);
    check("after reset partial", fv_cnt, exp_fv);
    scan_hex(3, 0, 1'b0, 15);
    scan_hex(2, 0, 1'b0, 15);
    idle(3);
    check("00F0 chars", {char3, char2, char1, char0}, {5'h00, 5'h00, 5'h0F, 5'h00});
    check_frame("00F0");

    // Randomized frames with occasional too-short holds
    for (int fr = 0; fr < 8; fr++) begin
      for (int pos = 3; pos >= 0; pos--) begin
        if ($urandom_range(0, 3) == 0)
          scan_hex(pos, int'($urandom_range(0, 16)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
        scan_hex(pos, int'($urandom_range(0, 16)), 1'($urandom_range(0, 1)), int'($urandom_range(8, 20)));
      end
      idle(3);
      check_frame("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
